edge_detect: RTL and testbench
==============================

// Module: edge_detect
// PURPOSE
// - Streaming edge classifier for the cartoon filter datapath.
// - Each cycle accepts one 3x3 window of 24bpp RGB pixels and converts each pixel to 8-bit intensity.
// - Applies a Sobel operator to the window and flags the centre pixel as an edge when gradient magnitude exceeds a programmable threshold.
// - Sits between the frame-window fetch logic and the pixel recolour stage (edge pixels are painted black downstream).
// PARAMETERS
// - none: window fixed at 3x3, pixel fixed at 24 bpp (8.8.8), intensity fixed at 8 bits.
// PORTS
// - clk         input   1    system clock, all state on rising edge
// - n_rst       input   1    asynchronous reset, active low
// - pixelData   input   216  3x3 RGB window; pixel p (0..8, raster order, 0=top-left, 4=centre) at [215-24p -: 24]; within a pixel R=[23:16], G=[15:8], B=[7:0]
// - iThreshold  input   8    edge threshold, unsigned
// - iGrid       output  72   registered intensity window; pixel p at [71-8p -: 8]
// - isEdge      output  1    registered edge flag for the centre pixel of the window
// BEHAVIOUR
// - Reset (n_rst=0, async): iGrid=72'd0, isEdge=0 immediately, independent of clk; held until n_rst=1.
// - No handshake. A new window is accepted every cycle; pipeline never stalls.
// - Stage 1 (intensity), per pixel:
//   - I = (R + 2*G + B) >> 2, computed in 10-bit unsigned then truncated; range 0..255.
//   - All 9 results registered into iGrid on the next rising clk.
// - Stage 2 (Sobel), using registered iGrid, with q0..q8 = iGrid pixels:
//   - Gx = (q2 + 2*q5 + q8) - (q0 + 2*q3 + q6), signed 11-bit, range -1020..1020.
//   - Gy = (q6 + 2*q7 + q8) - (q0 + 2*q1 + q2), signed 11-bit.
//   - mag = |Gx| + |Gy|, unsigned 11-bit, range 0..2040; no saturation needed.
//   - Centre pixel q4 is unused.
//   - isEdge registered = (mag > {3'b0, iThreshold}). Strictly greater; equality gives 0.
// - iThreshold is sampled in stage 2: the value present at the clock edge that registers isEdge is used.
// - Latency:
//   - pixelData sampled at edge N -> iGrid valid after edge N -> isEdge valid after edge N+1 (2 clocks).
//   - Results emerge in input order, one per cycle.
// - Reset mid-stream: all in-flight windows are discarded. First valid isEdge appears 2 edges after the first post-reset window.
// - Outputs hold their last value while the input is unchanged (recomputed identically each cycle).
// TESTING
// - Reset: drive n_rst=0 with non-zero pixelData -> iGrid=0 and isEdge=0 without a clock edge; both stay 0 while reset is held.
// - Intensity weights: all pixels R=0x40, G=0x80, B=0xC0 -> iGrid = 9 bytes of 0x80 one clock later; isEdge=0 with iThreshold=90.
// - Vertical edge: left column 0x000000, others 0xFFFFFF, iThreshold=90 -> iGrid rows {00,FF,FF}; Gx=1020, Gy=0; isEdge=1 after 2 clocks.
// - Threshold boundary: left column 0x000000, others 0x171717 (I=23) -> mag=92; iThreshold=92 -> isEdge=0; iThreshold=91 -> isEdge=1.
// - Flat field: all pixels 0x808080, any iThreshold -> mag=0, isEdge=0; all-white with iThreshold=0 -> isEdge=0.
// - Streaming: alternate vertical-edge and flat windows on consecutive cycles -> isEdge toggles 1,0,1,0 two cycles behind input, no bubbles; assert n_rst mid-stream -> isEdge=0 at once, valid again 2 clocks after release.

Source files
------------

// File: rtl/edge_detect.sv
// Streaming Sobel edge classifier: 3x3 RGB window in, registered intensity
// window and centre-pixel edge flag out. Two-stage pipeline, no stalls.

// Per-pixel RGB -> 8-bit intensity, I = (R + 2G + B) >> 2.
module edge_intensity (
  input  logic [23:0] pix,
  output logic [7:0]  inten
);
  logic [9:0] sum;
  logic [1:0] unused_frac;

  // Full-precision weighted sum; dropping the two LSBs is the divide by 4.
  assign sum = {2'b0, pix[23:16]} + {1'b0, pix[15:8], 1'b0} + {2'b0, pix[7:0]};
  assign {inten, unused_frac} = sum;
endmodule

module edge_detect (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [215:0] pixelData,
  input  logic [7:0]   iThreshold,
  output logic [71:0]  iGrid,
  output logic         isEdge
);
  // Element 8 sits in the top byte, so pixel p lives at index 8-p.
  logic [8:0][7:0] grid_d;
  logic [8:0][7:0] grid_q;

  logic [7:0] q0, q1, q2, q3, q5, q6, q7, q8;
  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic signed [10:0] gx, gy;
  logic [10:0] ax, ay, mag;

  // Stage 1: one intensity converter per window pixel.
  for (genvar p = 0; p < 9; p++) begin : g_px
    edge_intensity u_int (
      .pix   (pixelData[215-24*p -: 24]),
      .inten (grid_d[8-p])
    );
  end

  // Stage 1 register: intensity window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) grid_q <= '0;
    else        grid_q <= grid_d;
  end

  assign iGrid = grid_q;

  assign q0 = grid_q[8];
  assign q1 = grid_q[7];
  assign q2 = grid_q[6];
  assign q3 = grid_q[5];
  assign q5 = grid_q[3];
  assign q6 = grid_q[2];
  assign q7 = grid_q[1];
  assign q8 = grid_q[0];

  // Stage 2 combinational Sobel: each half-kernel sum is at most 1020, so
  // 10 bits per side and an 11-bit signed difference cannot overflow.
  always_comb begin
    gx_p = {2'b0, q2} + {1'b0, q5, 1'b0} + {2'b0, q8};
    gx_n = {2'b0, q0} + {1'b0, q3, 1'b0} + {2'b0, q6};
    gy_p = {2'b0, q6} + {1'b0, q7, 1'b0} + {2'b0, q8};
    gy_n = {2'b0, q0} + {1'b0, q1, 1'b0} + {2'b0, q2};
    gx   = $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
    gy   = $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
    ax   = gx[10] ? (~gx + 11'sd1) : gx;
    ay   = gy[10] ? (~gy + 11'sd1) : gy;
    mag  = ax + ay;
  end

  // Stage 2 register: strict compare against the threshold present now.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) isEdge <= 1'b0;
    else        isEdge <= (mag > {3'b0, iThreshold});
  end
endmodule

// File: tb/tb_edge_detect.sv
// Scoreboarded bench for edge_detect: stimulus pushes hand-computed results
// with the cycle they are due; a negedge monitor pops and compares.
module tb_edge_detect;
  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic [215:0] pixelData = '0;
  logic [7:0]   iThreshold = '0;
  logic [71:0]  iGrid;
  logic         isEdge;

  edge_detect dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .pixelData  (pixelData),
    .iThreshold (iThreshold),
    .iGrid      (iGrid),
    .isEdge     (isEdge)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] val;
    int          due;
    int          id;
  } exp_t;

  exp_t gq[$];
  exp_t eq[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic [7:0] pend_thr = 8'd0;

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] K = 24'h000000;
  localparam logic [23:0] S = 24'h171717;
  localparam logic [23:0] M = 24'h808080;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      while (gq.size() > 0 && gq[0].due <= cyc) begin
        e = gq.pop_front();
        checks++;
        if (iGrid !== e.val) begin
          fails++;
          $display("FAIL grid v%0d: got %h want %h", e.id, iGrid, e.val);
        end
      end
      while (eq.size() > 0 && eq[0].due <= cyc) begin
        e = eq.pop_front();
        checks++;
        if (isEdge !== e.val[0]) begin
          fails++;
          $display("FAIL edge v%0d: got %b want %b", e.id, isEdge, e.val[0]);
        end
      end
    end
  end

  function automatic logic [215:0] win(input logic [23:0] a, b, c, d, e, f, g, h, i);
    return {a, b, c, d, e, f, g, h, i};
  endfunction

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // thr is the threshold judged against this window; it is driven one
  // cycle later, when the window's Sobel result is being registered.
  task automatic issue(input int id, input logic [215:0] w, input logic [7:0] thr,
                       input logic [71:0] g, input logic e);
    pixelData  = w;
    iThreshold = pend_thr;
    pend_thr   = thr;
    gq.push_back('{g, cyc + 1, id});
    eq.push_back('{{71'd0, e}, cyc + 2, id});
    @(posedge clk); #1;
  endtask

  task automatic flush(input int n);
    repeat (n) begin
      iThreshold = pend_thr;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Fill the pipe with a vertical edge so reset has something to clear.
    pixelData  = win(K, W, W, K, W, W, K, W, W);
    iThreshold = 8'd90;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_edge", {71'd0, isEdge}, 72'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_async_grid", iGrid, 72'd0);
    chk("rst_async_edge", {71'd0, isEdge}, 72'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_grid", iGrid, 72'd0);
    chk("rst_hold_edge", {71'd0, isEdge}, 72'd0);
    n_rst = 1'b1;

    issue(1, win(24'h4080C0, 24'h4080C0, 24'h4080C0, 24'h4080C0, 24'h4080C0,
                 24'h4080C0, 24'h4080C0, 24'h4080C0, 24'h4080C0),
          8'd90, 72'h808080_808080_808080, 1'b0);
    issue(2, win(K, W, W, K, W, W, K, W, W), 8'd90, 72'h00FFFF_00FFFF_00FFFF, 1'b1);
    issue(3, win(K, S, S, K, S, S, K, S, S), 8'd92, 72'h001717_001717_001717, 1'b0);
    issue(4, win(K, S, S, K, S, S, K, S, S), 8'd91, 72'h001717_001717_001717, 1'b1);
    issue(5, win(M, M, M, M, M, M, M, M, M), 8'd0,  72'h808080_808080_808080, 1'b0);
    issue(6, win(W, W, W, W, W, W, W, W, W), 8'd0,  72'hFFFFFF_FFFFFF_FFFFFF, 1'b0);
    issue(7, win(K, K, K, W, W, W, W, W, W), 8'd200, 72'h000000_FFFFFF_FFFFFF, 1'b1);
    issue(8, win(W, W, K, W, W, K, W, W, K), 8'd255, 72'hFFFF00_FFFF00_FFFF00, 1'b1);
    issue(9, win(24'hFF0000, 24'h00FF00, 24'h0000FF, K, K, K, K, K, K),
          8'd255, 72'h3F7F3F_000000_000000, 1'b1);
    issue(10, win(24'hFF0000, K, K, K, K, K, K, K, K), 8'd126,
          72'h3F0000_000000_000000, 1'b0);
    issue(11, win(24'hFF0000, K, K, K, K, K, K, K, K), 8'd125,
          72'h3F0000_000000_000000, 1'b1);

    // Back-to-back alternation, no bubbles.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) issue(20 + i, win(K, W, W, K, W, W, K, W, W), 8'd90,
                            72'h00FFFF_00FFFF_00FFFF, 1'b1);
      else            issue(20 + i, win(M, M, M, M, M, M, M, M, M), 8'd90,
                            72'h808080_808080_808080, 1'b0);
    end

    // Reset mid-stream: in-flight windows are dropped.
    #2 n_rst = 1'b0;
    gq.delete();
    eq.delete();
    #1;
    chk("mid_rst_grid", iGrid, 72'd0);
    chk("mid_rst_edge", {71'd0, isEdge}, 72'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_hold", {71'd0, isEdge}, 72'd0);
    n_rst = 1'b1;

    issue(30, win(K, W, W, K, W, W, K, W, W), 8'd90, 72'h00FFFF_00FFFF_00FFFF, 1'b1);
    issue(31, win(M, M, M, M, M, M, M, M, M), 8'd90, 72'h808080_808080_808080, 1'b0);
    issue(32, win(K, W, W, K, W, W, K, W, W), 8'd90, 72'h00FFFF_00FFFF_00FFFF, 1'b1);
    flush(4);

    checks++;
    if (gq.size() != 0 || eq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", gq.size(), eq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
